// File: rtl/fifo2axi4_pkg.sv
// ============================================================================
// Module  : fifo2axi4_pkg
// Brief   : Shared AXI4 constants, writer FSM states and size helper.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo2axi4_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AW   = 2'd1,
    W    = 2'd2,
    B    = 2'd3
  } state_t;

  function automatic logic [2:0] axsize(input int dw);
    return 3'($clog2(dw / 8));
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo2axi4_wr_if.sv
// ============================================================================
// Module  : fifo2axi4_wr_if
// Brief   : FIFO read port plus AXI4 AW/W/B channels of the frame writer.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo2axi4_wr_if #(
  parameter int FAW    = 8,
  parameter int DATA_W = 128,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);

  logic              frd_vld;
  logic              frd_rdy;
  logic [DATA_W-1:0] frd_dat;
  logic [FAW:0]      frd_cnt;

  logic [ID_W-1:0]     M_AXI_AWID;
  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic [7:0]          M_AXI_AWLEN;
  logic [2:0]          M_AXI_AWSIZE;
  logic [1:0]          M_AXI_AWBURST;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;

  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WLAST;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;

  logic [ID_W-1:0]     M_AXI_BID;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;

  modport master (
    input  frd_vld, frd_dat, frd_cnt,
    output frd_rdy,
    output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY
  );

  modport slave (
    output frd_vld, frd_dat, frd_cnt,
    input  frd_rdy,
    input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY
  );

endinterface

`default_nettype wire

// File: rtl/fifo2axi4_addr_gen.sv
// ============================================================================
// Module  : fifo2axi4_addr_gen
// Brief   : Circular frame-buffer burst address with frame wrap and done pulse.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo2axi4_addr_gen #(
  parameter int                  ADDR_W       = 32,
  parameter int                  DATA_W       = 128,
  parameter int                  BURST_LEN    = 16,
  parameter logic [ADDR_W-1:0]   BASE_ADDR    = 32'h1000_0000,
  parameter int                  FRAME_BURSTS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_frame_done
);

  localparam int                c_BCW        = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
  localparam logic [ADDR_W-1:0] c_STEP       = ADDR_W'(BURST_LEN * DATA_W / 8);
  localparam logic [c_BCW-1:0]  c_LAST_BURST = c_BCW'(FRAME_BURSTS - 1);

  logic [ADDR_W-1:0] r_addr;
  logic [c_BCW-1:0]  r_burst_cnt;
  logic              r_frame_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= BASE_ADDR;
      r_burst_cnt  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (i_advance) begin
        if (r_burst_cnt == c_LAST_BURST) begin
          r_addr       <= BASE_ADDR;
          r_burst_cnt  <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_addr      <= r_addr + c_STEP;
          r_burst_cnt <= r_burst_cnt + 1'b1;
        end
      end
    end
  end

  assign o_addr       = r_addr;
  assign o_frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: rtl/fifo2axi4_wr.sv
// ============================================================================
// Module  : fifo2axi4_wr
// Brief   : Drains FIFO words into fixed-length AXI4 INCR bursts, one in flight.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo2axi4_wr
  import fifo2axi4_pkg::*;
#(
  parameter int                           FAW             = 8,
  parameter int                           AXI4_DATA_WIDTH = 128,
  parameter int                           AXI4_ADDR_WIDTH = 32,
  parameter int                           AXI4_ID_WIDTH   = 4,
  parameter int                           BURST_LEN       = 16,
  parameter logic [AXI4_ADDR_WIDTH-1:0]   BASE_ADDR       = 32'h1000_0000,
  parameter int                           FRAME_BURSTS    = 1024
) (
  input  logic           M_AXI_ACLK,
  input  logic           M_AXI_ARESET,
  fifo2axi4_wr_if.master m_if,
  output logic           wr_busy,
  output logic           frame_done,
  output logic           resp_err
);

  localparam int                         c_BURST_BYTES = BURST_LEN * AXI4_DATA_WIDTH / 8;
  localparam logic [7:0]                 c_LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [FAW:0]               c_START_LVL   = (FAW + 1)'(BURST_LEN);
  localparam logic [AXI4_ADDR_WIDTH-1:0] c_ALIGN       = AXI4_ADDR_WIDTH'(c_BURST_BYTES);

  if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_burst_len
    $error("fifo2axi4_wr: BURST_LEN must be in 1..256");
  end
  if (BURST_LEN > (1 << FAW)) begin : g_bad_fifo_depth
    $error("fifo2axi4_wr: BURST_LEN exceeds FIFO depth");
  end
  if ((BASE_ADDR % c_ALIGN) != '0) begin : g_bad_base_align
    $error("fifo2axi4_wr: BASE_ADDR not aligned to burst size");
  end

  state_t                     r_state;
  state_t                     w_next;
  logic [7:0]                 r_beat_cnt;
  logic                       r_resp_err;
  logic                       w_last_beat;
  logic                       w_w_hs;
  logic                       w_b_hs;
  logic [AXI4_ADDR_WIDTH-1:0] w_awaddr;
  logic                       w_unused;

  assign w_last_beat = (r_beat_cnt == c_LAST_BEAT);
  assign w_w_hs      = (r_state == W) && m_if.frd_vld && m_if.M_AXI_WREADY;
  assign w_b_hs      = (r_state == B) && m_if.M_AXI_BVALID;
  assign w_unused    = ^m_if.M_AXI_BID;

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
      r_resp_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_w_hs) begin
        r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
      end
      if (w_b_hs && (m_if.M_AXI_BRESP != AXI_RESP_OKAY)) begin
        r_resp_err <= 1'b1;
      end
    end
  end

  // Valids are decoded from state so an asynchronous reset drops them at once.
  always_comb begin
    w_next              = r_state;
    m_if.M_AXI_AWVALID  = 1'b0;
    m_if.M_AXI_WVALID   = 1'b0;
    m_if.M_AXI_WLAST    = 1'b0;
    m_if.M_AXI_BREADY   = 1'b0;
    m_if.frd_rdy        = 1'b0;
    case (r_state)
      IDLE: begin
        if (m_if.frd_cnt >= c_START_LVL) w_next = AW;
      end
      AW: begin
        m_if.M_AXI_AWVALID = 1'b1;
        if (m_if.M_AXI_AWREADY) w_next = W;
      end
      W: begin
        m_if.M_AXI_WVALID = m_if.frd_vld;
        m_if.M_AXI_WLAST  = w_last_beat;
        m_if.frd_rdy      = m_if.M_AXI_WREADY;
        if (w_w_hs && w_last_beat) w_next = B;
      end
      B: begin
        m_if.M_AXI_BREADY = 1'b1;
        if (m_if.M_AXI_BVALID) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  fifo2axi4_addr_gen #(
    .ADDR_W       (AXI4_ADDR_WIDTH),
    .DATA_W       (AXI4_DATA_WIDTH),
    .BURST_LEN    (BURST_LEN),
    .BASE_ADDR    (BASE_ADDR),
    .FRAME_BURSTS (FRAME_BURSTS)
  ) u_addr_gen (
    .clk          (M_AXI_ACLK),
    .rst          (M_AXI_ARESET),
    .i_advance    (w_b_hs),
    .o_addr       (w_awaddr),
    .o_frame_done (frame_done)
  );

  assign m_if.M_AXI_AWID    = '0;
  assign m_if.M_AXI_AWADDR  = w_awaddr;
  assign m_if.M_AXI_AWLEN   = c_LAST_BEAT;
  assign m_if.M_AXI_AWSIZE  = axsize(AXI4_DATA_WIDTH);
  assign m_if.M_AXI_AWBURST = AXI_BURST_INCR;
  assign m_if.M_AXI_WDATA   = m_if.frd_dat;
  assign m_if.M_AXI_WSTRB   = '1;

  assign wr_busy  = (r_state != IDLE);
  assign resp_err = r_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_fifo2axi4_wr.sv
// ============================================================================
// Module  : tb_fifo2axi4_wr
// Brief   : Randomised bench with a queue-based FIFO and AXI slave model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo2axi4_wr;

  localparam int          FAW          = 8;
  localparam int          DW           = 128;
  localparam int          AWD          = 32;
  localparam int          IDW          = 4;
  localparam int          BURST_LEN    = 16;
  localparam logic [31:0] BASE_ADDR    = 32'h1000_0000;
  localparam int          FRAME_BURSTS = 2;
  localparam int          BURST_BYTES  = BURST_LEN * DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_busy, frame_done, resp_err;

  always #5 clk = ~clk;

  fifo2axi4_wr_if #(.FAW(FAW), .DATA_W(DW), .ADDR_W(AWD), .ID_W(IDW)) bus ();

  fifo2axi4_wr #(
    .FAW(FAW), .AXI4_DATA_WIDTH(DW), .AXI4_ADDR_WIDTH(AWD), .AXI4_ID_WIDTH(IDW),
    .BURST_LEN(BURST_LEN), .BASE_ADDR(BASE_ADDR), .FRAME_BURSTS(FRAME_BURSTS)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESET (rst),
    .m_if         (bus),
    .wr_busy      (wr_busy),
    .frame_done   (frame_done),
    .resp_err     (resp_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [31:0]   aw_log[$];
  int            gap_log[$];

  int aw_cnt, w_cnt, pop_cnt, b_cnt, fd_cnt, viol, data_err, wlast_cnt, fd_at_b;
  int beat_idx, cyc, last_b_cyc, b_wait;
  bit aw_open, aw_stall_prev, w_stall_prev, aw_v_prev, pend_pop, pend_b_start, pend_b_done, b_arm;
  logic [31:0]   aw_addr_prev;
  logic [DW-1:0] wdata_prev;
  logic [7:0]    last_awlen;
  logic [2:0]    last_awsize;
  logic [1:0]    last_awburst;
  int            aw_pct = 100;
  int            w_pct  = 100;
  logic [1:0]    bresp_val = 2'b00;

  function automatic void refresh();
    bus.frd_vld = (fifo_q.size() != 0);
    bus.frd_dat = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    bus.frd_cnt = 9'(fifo_q.size());
  endfunction

  function automatic void clear_state(input bit flush);
    pend_pop = 0; pend_b_start = 0; pend_b_done = 0; b_arm = 0;
    bus.M_AXI_BVALID = 1'b0;
    aw_open = 0; beat_idx = 0; aw_stall_prev = 0; w_stall_prev = 0; aw_v_prev = 0;
    aw_cnt = 0; w_cnt = 0; pop_cnt = 0; b_cnt = 0; fd_cnt = 0; viol = 0;
    data_err = 0; wlast_cnt = 0; fd_at_b = -1; last_b_cyc = -1;
    aw_log.delete(); gap_log.delete();
    if (flush) begin
      fifo_q.delete(); exp_q.delete();
    end
    refresh();
  endfunction

  // Observe at the falling edge what the next rising edge will commit.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (aw_stall_prev && (!bus.M_AXI_AWVALID || bus.M_AXI_AWADDR !== aw_addr_prev)) viol++;
      aw_stall_prev = bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY;
      aw_addr_prev  = bus.M_AXI_AWADDR;
      if (w_stall_prev && (!bus.M_AXI_WVALID || bus.M_AXI_WDATA !== wdata_prev)) viol++;
      w_stall_prev = bus.M_AXI_WVALID && !bus.M_AXI_WREADY;
      wdata_prev   = bus.M_AXI_WDATA;
      if (bus.frd_rdy && !bus.M_AXI_WREADY) viol++;
      if (bus.M_AXI_WVALID && !aw_open) viol++;
      if (bus.M_AXI_AWVALID && !aw_v_prev && last_b_cyc >= 0) gap_log.push_back(cyc - last_b_cyc);
      aw_v_prev = bus.M_AXI_AWVALID;
      if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
        aw_cnt++; aw_log.push_back(bus.M_AXI_AWADDR); aw_open = 1;
        last_awlen = bus.M_AXI_AWLEN; last_awsize = bus.M_AXI_AWSIZE; last_awburst = bus.M_AXI_AWBURST;
      end
      if (bus.frd_vld && bus.frd_rdy) begin
        pop_cnt++; pend_pop = 1;
      end
      if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
        w_cnt++;
        if (exp_q.size() == 0 || bus.M_AXI_WDATA !== exp_q[0]) data_err++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (bus.M_AXI_WLAST !== (beat_idx == BURST_LEN - 1)) viol++;
        if (bus.M_AXI_WSTRB !== '1) viol++;
        beat_idx++;
        if (bus.M_AXI_WLAST) begin
          wlast_cnt++; beat_idx = 0; aw_open = 0; pend_b_start = 1;
        end
      end
      if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin
        b_cnt++; last_b_cyc = cyc; pend_b_done = 1;
      end
      if (frame_done) begin
        fd_cnt++; fd_at_b = b_cnt;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (pend_pop) begin
      void'(fifo_q.pop_front()); pend_pop = 0;
    end
    if (pend_b_done) begin
      bus.M_AXI_BVALID = 1'b0; pend_b_done = 0;
    end
    if (pend_b_start) begin
      b_wait = $urandom_range(0, 2); pend_b_start = 0; b_arm = 1;
    end
    if (b_arm) begin
      if (b_wait == 0) begin
        bus.M_AXI_BVALID = 1'b1; bus.M_AXI_BRESP = bresp_val; b_arm = 0;
      end else begin
        b_wait--;
      end
    end
    bus.M_AXI_AWREADY = ($urandom_range(0, 99) < aw_pct);
    bus.M_AXI_WREADY  = ($urandom_range(0, 99) < w_pct);
    refresh();
  end

  task automatic push_words(input int n);
    logic [DW-1:0] w;
    @(posedge clk); #2;
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      fifo_q.push_back(w); exp_q.push_back(w);
    end
    refresh();
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1; clear_state(1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_bursts(input int n, input int budget, input string tag);
    int k = 0;
    while (b_cnt < n && k < budget) begin
      @(posedge clk); k++;
    end
    n_checks++;
    if (b_cnt < n) begin
      n_fail++; $display("FAIL %s_timeout: bresp count=%0d required=%0d", tag, b_cnt, n);
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_WLAST, bus.M_AXI_BREADY, bus.frd_rdy} !== 5'b0) begin
      n_fail++; $display("FAIL reset_valids: got=%b required=00000", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_WLAST, bus.M_AXI_BREADY, bus.frd_rdy});
    end
    n_checks++;
    if ({wr_busy, frame_done, resp_err} !== 3'b0) begin
      n_fail++; $display("FAIL reset_status: got=%b required=000", {wr_busy, frame_done, resp_err});
    end
    n_checks++;
    if (bus.M_AXI_AWADDR !== BASE_ADDR) begin
      n_fail++; $display("FAIL reset_awaddr: got=%h required=%h", bus.M_AXI_AWADDR, BASE_ADDR);
    end
    n_checks++;
    if (bus.M_AXI_AWID !== '0 || bus.M_AXI_AWBURST !== 2'b01 || bus.M_AXI_WSTRB !== '1) begin
      n_fail++; $display("FAIL reset_consts: awid=%h awburst=%b wstrb=%h required 0/01/ffff", bus.M_AXI_AWID, bus.M_AXI_AWBURST, bus.M_AXI_WSTRB);
    end
  endtask

  task automatic test_single_burst();
    do_reset();
    push_words(BURST_LEN);
    wait_bursts(1, 200, "single");
    n_checks++;
    if (aw_cnt !== 1 || aw_log.size() == 0 || aw_log[0] !== BASE_ADDR) begin
      n_fail++; $display("FAIL single_aw: count=%0d addr=%h required 1/%h", aw_cnt, (aw_log.size() != 0) ? aw_log[0] : 32'hx, BASE_ADDR);
    end
    n_checks++;
    if (last_awlen !== 8'd15 || last_awsize !== 3'd4 || last_awburst !== 2'b01) begin
      n_fail++; $display("FAIL single_awfields: len=%0d size=%0d burst=%b required 15/4/01", last_awlen, last_awsize, last_awburst);
    end
    n_checks++;
    if (w_cnt !== BURST_LEN || pop_cnt !== BURST_LEN || wlast_cnt !== 1) begin
      n_fail++; $display("FAIL single_beats: beats=%0d pops=%0d wlast=%0d required 16/16/1", w_cnt, pop_cnt, wlast_cnt);
    end
    n_checks++;
    if (data_err !== 0 || viol !== 0) begin
      n_fail++; $display("FAIL single_protocol: data_err=%0d viol=%0d required 0/0", data_err, viol);
    end
    n_checks++;
    if (fifo_q.size() !== 0) begin
      n_fail++; $display("FAIL single_fifo_left: got=%0d required=0", fifo_q.size());
    end
  endtask

  task automatic test_threshold();
    int seen = 0;
    do_reset();
    push_words(BURST_LEN - 1);
    repeat (20) begin
      @(negedge clk);
      if (bus.M_AXI_AWVALID) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL thresh_hold: awvalid cycles=%0d required=0", seen);
    end
    push_words(1);
    @(negedge clk);
    n_checks++;
    if (bus.M_AXI_AWVALID !== 1'b0) begin
      n_fail++; $display("FAIL thresh_same_cycle: awvalid=%b required=0", bus.M_AXI_AWVALID);
    end
    @(negedge clk);
    n_checks++;
    if (bus.M_AXI_AWVALID !== 1'b1 || wr_busy !== 1'b1) begin
      n_fail++; $display("FAIL thresh_next_cycle: awvalid=%b busy=%b required 1/1", bus.M_AXI_AWVALID, wr_busy);
    end
    wait_bursts(1, 200, "thresh");
    n_checks++;
    if (data_err !== 0 || w_cnt !== BURST_LEN) begin
      n_fail++; $display("FAIL thresh_data: data_err=%0d beats=%0d required 0/16", data_err, w_cnt);
    end
  endtask

  task automatic test_stalls();
    do_reset();
    aw_pct = 30; w_pct = 50;
    push_words(3 * BURST_LEN);
    wait_bursts(3, 3000, "stall");
    aw_pct = 100; w_pct = 100;
    n_checks++;
    if (w_cnt !== 3 * BURST_LEN || pop_cnt !== 3 * BURST_LEN || wlast_cnt !== 3) begin
      n_fail++; $display("FAIL stall_beats: beats=%0d pops=%0d wlast=%0d required 48/48/3", w_cnt, pop_cnt, wlast_cnt);
    end
    n_checks++;
    if (data_err !== 0) begin
      n_fail++; $display("FAIL stall_order: data_err=%0d required=0", data_err);
    end
    n_checks++;
    if (viol !== 0) begin
      n_fail++; $display("FAIL stall_protocol: violations=%0d required=0", viol);
    end
  endtask

  task automatic test_frame_wrap();
    logic [31:0] exp_addr;
    do_reset();
    push_words(3 * BURST_LEN);
    wait_bursts(3, 500, "wrap");
    n_checks++;
    if (aw_cnt !== 3) begin
      n_fail++; $display("FAIL wrap_count: bursts=%0d required=3", aw_cnt);
    end
    for (int k = 0; k < aw_log.size(); k++) begin
      exp_addr = BASE_ADDR + 32'((k % FRAME_BURSTS) * BURST_BYTES);
      n_checks++;
      if (aw_log[k] !== exp_addr) begin
        n_fail++; $display("FAIL wrap_addr%0d: got=%h required=%h", k, aw_log[k], exp_addr);
      end
    end
    n_checks++;
    if (fd_cnt !== 3 / FRAME_BURSTS || fd_at_b !== FRAME_BURSTS) begin
      n_fail++; $display("FAIL wrap_frame_done: pulses=%0d after_bresp=%0d required %0d/%0d", fd_cnt, fd_at_b, 3 / FRAME_BURSTS, FRAME_BURSTS);
    end
    n_checks++;
    if (gap_log.size() < 2 || gap_log[0] !== 2 || gap_log[1] !== 2) begin
      n_fail++; $display("FAIL wrap_spacing: gaps=%0d first=%0d required 2 gaps of 2", gap_log.size(), (gap_log.size() != 0) ? gap_log[0] : -1);
    end
  endtask

  task automatic test_resp_err();
    do_reset();
    bresp_val = 2'b10;
    push_words(BURST_LEN);
    wait_bursts(1, 200, "err1");
    bresp_val = 2'b00;
    @(negedge clk);
    n_checks++;
    if (resp_err !== 1'b1) begin
      n_fail++; $display("FAIL err_set: resp_err=%b required=1", resp_err);
    end
    push_words(BURST_LEN);
    wait_bursts(2, 200, "err2");
    @(negedge clk);
    n_checks++;
    if (resp_err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: resp_err=%b required=1", resp_err);
    end
    n_checks++;
    if (aw_log.size() < 2 || aw_log[1] !== BASE_ADDR + BURST_BYTES) begin
      n_fail++; $display("FAIL err_next_addr: bursts=%0d required addr=%h", aw_log.size(), BASE_ADDR + BURST_BYTES);
    end
    n_checks++;
    if (w_cnt !== 2 * BURST_LEN || data_err !== 0) begin
      n_fail++; $display("FAIL err_data: beats=%0d data_err=%0d required 32/0", w_cnt, data_err);
    end
  endtask

  task automatic test_reset_midburst();
    int k = 0;
    do_reset();
    push_words(BURST_LEN);
    while (w_cnt < 6 && k < 200) begin
      @(posedge clk); k++;
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_WLAST, bus.M_AXI_BREADY, bus.frd_rdy, wr_busy} !== 6'b0) begin
      n_fail++; $display("FAIL midrst_valids: got=%b required=000000", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_WLAST, bus.M_AXI_BREADY, bus.frd_rdy, wr_busy});
    end
    clear_state(0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.M_AXI_AWADDR !== BASE_ADDR || wr_busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_restart: addr=%h busy=%b required %h/0", bus.M_AXI_AWADDR, wr_busy, BASE_ADDR);
    end
    n_checks++;
    if (fifo_q.size() !== BURST_LEN - 6) begin
      n_fail++; $display("FAIL midrst_fifo_left: got=%0d required=%0d", fifo_q.size(), BURST_LEN - 6);
    end
    push_words(6);
    wait_bursts(1, 200, "midrst");
    n_checks++;
    if (aw_log.size() == 0 || aw_log[0] !== BASE_ADDR || w_cnt !== BURST_LEN || data_err !== 0) begin
      n_fail++; $display("FAIL midrst_burst: bursts=%0d beats=%0d data_err=%0d required 1 at %h/16/0", aw_log.size(), w_cnt, data_err, BASE_ADDR);
    end
  endtask

  initial begin
    bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0;
    bus.M_AXI_BID = '0; bus.M_AXI_BRESP = 2'b00;
    clear_state(1);
    test_reset();
    test_single_burst();
    test_threshold();
    test_stalls();
    test_frame_wrap();
    test_resp_err();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
